panel_scan_ctrl: RTL and testbench
==================================

Name: panel_scan_ctrl

Overview:
- Scan sequencer for the 32x32 HUB75-style LED panel: row pairs selected by PANEL_[ABCD], blanking by PANEL_OE (active low), serial colour data clocked by PANEL_CLK, latched by PANEL_STB.
- Fetches pixels from a double-buffered frame memory, one read port, one read per cycle.
- Serialises each bit-plane and applies binary-coded-modulation on-times.
- Swaps front/back buffer only at frame boundaries, under a req/ack handshake from the pixel producer.

Parameters:
- COLS, 32, columns per row; power of two, max 32.
- PLANES, 8, colour bits per channel (bit-planes).
- BASE_ON, 2, OE-low cycles for plane 0; plane p lit BASE_ON<<p cycles.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- en  in  1  scan enable; sampled at frame/plane boundaries
- swap_req  in  1  producer requests buffer swap; level, held until ack
- swap_ack  out  1  one-cycle pulse: swap performed
- front_buf  out  1  buffer currently displayed
- mem_rd  out  1  read strobe
- mem_addr  out  11  {front_buf, y[4:0], x[4:0]}
- mem_rdata  in  3*PLANES  {r,g,b} pixel; valid exactly 1 cycle after mem_rd
- PANEL_R0, PANEL_G0, PANEL_B0, PANEL_R1, PANEL_G1, PANEL_B1  out  1 each  colour for top/bottom half
- PANEL_A, PANEL_B, PANEL_C, PANEL_D  out  1 each  row select (D = MSB)
- PANEL_CLK, PANEL_STB, PANEL_OE  out  1 each  shift clock, latch, output enable (low = lit)

Behaviour:
- Reset (async, resetn=0): all outputs 0 except PANEL_OE=1; state IDLE; row=0, plane=0, col=0, front_buf=0. Reset mid-frame aborts immediately; the panel is blank.
- States:
  - IDLE: OE=1. When en=1 → SHIFT.
  - SHIFT: COLS column slots, each 4 cycles t0..t3.
  - LATCH: 2 cycles.
  - DISPLAY: BASE_ON<<plane cycles.
- SHIFT slot for column x:
  - t0: mem_rd=1, addr y=row.
  - t1: mem_rd=1, addr y=row+16; top data captured.
  - t2: bottom data captured.
  - Edge ending t2 loads PANEL_R0/G0/B0 = top {r,g,b}[plane] and PANEL_R1/G1/B1 = bottom bits.
  - PANEL_CLK=1 exactly during t0 of slot x+1. For the last column it is high during LATCH cycle 0.
  - PANEL_CLK and colour outputs are registered. Colour is stable from t3 through t2 of the next slot: 1 cycle setup, 2 cycles hold.
- OE=1 throughout SHIFT and LATCH.
- LATCH cycle 1: PANEL_STB=1; {D,C,B,A} loaded with row in the same edge; colour outputs cleared to 0.
- DISPLAY: OE=0 for exactly BASE_ON<<plane cycles, then 1. Plane 7 with default parameters gives 256 cycles.
- Advance after DISPLAY:
  - plane==PLANES-1: plane=0, row=row+1 (4-bit wrap); otherwise plane+1.
  - Row wrap 15→0 is the frame end.
  - Next state is SHIFT if en=1, else IDLE. en is never sampled mid-plane.
- Swap: at frame end, if swap_req=1, front_buf toggles and swap_ack pulses 1 cycle, in the cycle the first SHIFT t0 reads the new buffer.
  - swap_req rising mid-frame waits for the frame end.
  - swap_req held after ack with no deassert is not a new request; it must drop for ≥1 cycle.
- Address widths: x zero-extended to 5 bits; y top = {0,row}, bottom = {1,row}.
- Plane period = 4*COLS + 2 + (BASE_ON<<plane) cycles. Default frame = 16*(8*130 + 2*255) = 24800 cycles.

Decomposition:
- Shared package panel_pkg:
  - state enum {IDLE, SHIFT, LATCH, DISPLAY};
  - constant ROWS_HALF=16;
  - address field widths;
  - typedef for pixel {r,g,b}.
- One natural sub-module: panel_bcm_timer. It is a loadable down-counter producing the DISPLAY on-time and done, loaded with BASE_ON<<plane.

Test Plan:
- Reset release with en=1, memory all-zero: first PANEL_CLK pulse at cycle 5 after reset release (slot 1 t0); 32 PANEL_CLK pulses, then STB=1 with {D,C,B,A}=0; OE low 2 cycles for plane 0, then 4 for plane 1.
- Pixel (x=3,y=0) r=0x80, pixel (3,16) b=0x01: R0=1 only on column 3 of plane 7; B1=1 only on column 3 of plane 0; all other colour bits 0.
- Count OE-low cycles per plane across one row: 2,4,8,...,256 exactly; STB count=8 per row, 128 per frame; frame length 24800 cycles.
- swap_req asserted mid-frame: no ack until row wraps; one-cycle ack; mem_addr[10] flips at the next t0; held swap_req gives no second ack.
- en dropped during SHIFT of plane 3: plane completes including DISPLAY, then IDLE with OE=1; re-enable resumes at plane 4 of the same row.
- resetn asserted during DISPLAY: OE=1 and STB=CLK=0 immediately (asynchronously), front_buf=0, swap_ack never pulses.

Source files
------------

// File: rtl/panel_pkg.sv
// rtl/panel_pkg.sv - shared types and field widths for the LED panel scan sequencer
package panel_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} scan_state_e;

  localparam int ROWS_HALF = 16;
  localparam int ROW_W     = 4;
  localparam int X_W       = 5;
  localparam int Y_W       = 5;
  localparam int ADDR_W    = 1 + Y_W + X_W;

  // One bit-plane slice of an {r,g,b} pixel
  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } pixel_bits_t;

endpackage

// File: rtl/panel_bcm_timer.sv
// rtl/panel_bcm_timer.sv - loadable down-counter timing the lit phase of one bit-plane
module panel_bcm_timer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  // Asserted in the last lit cycle, so a load of N gives exactly N cycles
  assign done = (cnt == W'(1));

endmodule

// File: rtl/panel_scan_ctrl.sv
// rtl/panel_scan_ctrl.sv - HUB75 scan sequencer: fetch, serialise, latch and BCM-light each bit-plane
module panel_scan_ctrl
  import panel_pkg::*;
#(
  parameter int COLS    = 32,
  parameter int PLANES  = 8,
  parameter int BASE_ON = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                en,
  input  logic                swap_req,
  output logic                swap_ack,
  output logic                front_buf,
  output logic                mem_rd,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [3*PLANES-1:0] mem_rdata,
  output logic                PANEL_R0,
  output logic                PANEL_G0,
  output logic                PANEL_B0,
  output logic                PANEL_R1,
  output logic                PANEL_G1,
  output logic                PANEL_B1,
  output logic                PANEL_A,
  output logic                PANEL_B,
  output logic                PANEL_C,
  output logic                PANEL_D,
  output logic                PANEL_CLK,
  output logic                PANEL_STB,
  output logic                PANEL_OE
);

  localparam int PLANE_W = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int ON_W    = $clog2((BASE_ON << (PLANES - 1)) + 1);

  scan_state_e        state, state_nxt;
  logic [1:0]         phase;
  logic [X_W-1:0]     col;
  logic               lat_cyc;
  logic [ROW_W-1:0]   row;
  logic [PLANE_W-1:0] plane;
  pixel_bits_t        top_q;
  logic               swap_armed;
  logic               on_done;
  logic               slot_end, shift_end, plane_end, frame_end, do_swap;

  function automatic pixel_bits_t plane_slice(input logic [3*PLANES-1:0] px,
                                              input logic [PLANE_W-1:0]  p);
    pixel_bits_t s;
    s.r = px[2*PLANES + int'(p)];
    s.g = px[PLANES + int'(p)];
    s.b = px[int'(p)];
    return s;
  endfunction

  assign slot_end  = (state == SHIFT) && (phase == 2'd3);
  assign shift_end = slot_end && (col == X_W'(COLS - 1));
  assign plane_end = (state == DISPLAY) && on_done;
  assign frame_end = plane_end && (plane == PLANE_W'(PLANES - 1)) && (row == ROW_W'(ROWS_HALF - 1));
  // A request only counts once swap_req has dropped since the previous ack
  assign do_swap   = frame_end && swap_req && swap_armed;

  assign mem_rd   = (state == SHIFT) && !phase[1];
  assign mem_addr = mem_rd ? {front_buf, phase[0], row, col} : '0;

  panel_bcm_timer #(.W(ON_W)) u_bcm_timer (
    .clk      (clk),
    .resetn   (resetn),
    .load     ((state == LATCH) && lat_cyc),
    .load_val (ON_W'(BASE_ON << plane)),
    .done     (on_done)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = SHIFT;
      SHIFT:   if (shift_end) state_nxt = LATCH;
      LATCH:   if (lat_cyc) state_nxt = DISPLAY;
      DISPLAY: if (on_done) state_nxt = en ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase   <= '0;
      col     <= '0;
      lat_cyc <= 1'b0;
      row     <= '0;
      plane   <= '0;
    end else begin
      if (state == SHIFT) begin
        phase <= phase + 2'd1;
        if (slot_end) col <= shift_end ? '0 : col + X_W'(1);
      end
      lat_cyc <= (state == LATCH) && !lat_cyc;
      if (plane_end) begin
        if (plane == PLANE_W'(PLANES - 1)) begin
          plane <= '0;
          row   <= row + ROW_W'(1);
        end else begin
          plane <= plane + PLANE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      top_q      <= '0;
      {PANEL_R0, PANEL_G0, PANEL_B0, PANEL_R1, PANEL_G1, PANEL_B1} <= '0;
      {PANEL_D, PANEL_C, PANEL_B, PANEL_A} <= '0;
      PANEL_CLK  <= 1'b0;
      PANEL_STB  <= 1'b0;
      PANEL_OE   <= 1'b1;
      swap_ack   <= 1'b0;
      front_buf  <= 1'b0;
      swap_armed <= 1'b1;
    end else begin
      // Shift edge lands one cycle after new colour: 1 cycle setup, 2 cycles hold
      PANEL_CLK <= slot_end;
      PANEL_STB <= (state == LATCH) && !lat_cyc;
      PANEL_OE  <= (state_nxt != DISPLAY);
      swap_ack  <= do_swap;
      if ((state == SHIFT) && (phase == 2'd1)) top_q <= plane_slice(mem_rdata, plane);
      if ((state == SHIFT) && (phase == 2'd2)) begin
        {PANEL_R0, PANEL_G0, PANEL_B0} <= top_q;
        {PANEL_R1, PANEL_G1, PANEL_B1} <= plane_slice(mem_rdata, plane);
      end else if ((state == LATCH) && !lat_cyc) begin
        {PANEL_R0, PANEL_G0, PANEL_B0, PANEL_R1, PANEL_G1, PANEL_B1} <= '0;
        {PANEL_D, PANEL_C, PANEL_B, PANEL_A} <= row;
      end
      if (do_swap) front_buf <= ~front_buf;
      if (do_swap) swap_armed <= 1'b0;
      else if (!swap_req) swap_armed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_panel_scan_ctrl.sv
// tb/tb_panel_scan_ctrl.sv - self-checking bench for panel_scan_ctrl against a plane-period model
module tb_panel_scan_ctrl;

  localparam int COLS      = 32;
  localparam int PLANES    = 8;
  localparam int BASE_ON   = 2;
  localparam int SHIFT_LEN = 4 * COLS;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic        swap_req = 1'b0;
  logic        swap_ack, front_buf, mem_rd;
  logic [10:0] mem_addr;
  logic [23:0] mem_rdata = '0;
  logic        r0, g0, b0, r1, g1, b1, pa, pb, pc, pd, pclk, pstb, poe;
  logic [23:0] mem [2048];

  int checks = 0;
  int errors = 0;
  int ack_total = 0;
  int cyc = 0;

  typedef struct {
    bit run;
    int t;
    int row;
    int plane;
    bit front;
    bit armed;
    int abcd;
    bit ack;
  } model_t;

  model_t m;

  panel_scan_ctrl #(.COLS(COLS), .PLANES(PLANES), .BASE_ON(BASE_ON)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .en        (en),
    .swap_req  (swap_req),
    .swap_ack  (swap_ack),
    .front_buf (front_buf),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .PANEL_R0  (r0),
    .PANEL_G0  (g0),
    .PANEL_B0  (b0),
    .PANEL_R1  (r1),
    .PANEL_G1  (g1),
    .PANEL_B1  (b1),
    .PANEL_A   (pa),
    .PANEL_B   (pb),
    .PANEL_C   (pc),
    .PANEL_D   (pd),
    .PANEL_CLK (pclk),
    .PANEL_STB (pstb),
    .PANEL_OE  (poe)
  );

  initial forever #5 clk = ~clk;

  // Read data is valid only the cycle after a strobe; garbage otherwise
  always @(posedge clk) mem_rdata <= mem_rd ? mem[mem_addr] : 24'($urandom);

  function automatic int period(input int p);
    return SHIFT_LEN + 2 + (BASE_ON << p);
  endfunction

  function automatic model_t model_reset();
    model_t r;
    r.run = 0; r.t = 0; r.row = 0; r.plane = 0;
    r.front = 0; r.armed = 1; r.abcd = 0; r.ack = 0;
    return r;
  endfunction

  function automatic model_t model_step(input model_t c, input logic e, input logic req);
    model_t n = c;
    n.ack = 0;
    if (!c.run) begin
      if (e) begin n.run = 1; n.t = 0; end
    end else if (c.t == period(c.plane) - 1) begin
      n.run = e;
      n.t = 0;
      n.plane = (c.plane + 1) % PLANES;
      if (n.plane == 0) begin
        n.row = (c.row + 1) % 16;
        if (n.row == 0 && req && c.armed) begin n.front = !c.front; n.ack = 1; end
      end
    end else begin
      n.t = c.t + 1;
      if (n.t == SHIFT_LEN + 1) n.abcd = c.row;
    end
    if (n.ack) n.armed = 0;
    else if (!req) n.armed = 1;
    return n;
  endfunction

  function automatic logic [26:0] expected(input model_t c);
    logic        rd, pclk_e, stb_e, oe_e;
    logic [10:0] addr;
    logic [5:0]  colr;
    logic [23:0] tp, bp;
    int          x;
    rd = 0; addr = '0; colr = '0; pclk_e = 0; stb_e = 0; oe_e = 1;
    if (c.run) begin
      if (c.t < SHIFT_LEN) begin
        rd = (c.t % 4) < 2;
        if (rd) addr = {c.front, 1'((c.t % 4) == 1), 4'(c.row), 5'(c.t / 4)};
      end
      pclk_e = (c.t >= 4) && (c.t <= SHIFT_LEN) && (c.t % 4 == 0);
      stb_e  = (c.t == SHIFT_LEN + 1);
      oe_e   = (c.t < SHIFT_LEN + 2);
      if (c.t >= 3 && c.t <= SHIFT_LEN) begin
        x = (c.t - 3) / 4;
        tp = mem[{c.front, 1'b0, 4'(c.row), 5'(x)}];
        bp = mem[{c.front, 1'b1, 4'(c.row), 5'(x)}];
        colr = {tp[16 + c.plane], tp[8 + c.plane], tp[c.plane],
                bp[16 + c.plane], bp[8 + c.plane], bp[c.plane]};
      end
    end
    return {c.ack, c.front, rd, addr, colr, 4'(c.abcd), pclk_e, stb_e, oe_e};
  endfunction

  function automatic logic [26:0] actual();
    return {swap_ack, front_buf, mem_rd, mem_addr, r0, g0, b0, r1, g1, b1,
            pd, pc, pb, pa, pclk, pstb, poe};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    m = model_reset();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) m = model_reset();
      else m = model_step(m, en, swap_req);
    end
  end

  initial forever begin
    @(negedge clk);
    check("scan_outputs", 32'(actual()), 32'(expected(m)));
    if (swap_ack) ack_total++;
  end

  initial begin
    int first_clk, clk_before_stb, stb_n, stb1, stb129, row0_stb, oe_run, run_n, n, low;
    int runs[8];
    int cnt_r0, cnt_b1, cnt_other;
    bit seen15;

    for (int i = 0; i < 2048; i++) mem[i] = (i < 1024) ? 24'h0 : 24'($urandom);
    mem[11'h003] = 24'h800000;
    mem[11'h203] = 24'h000001;
    for (int i = 0; i < 8; i++) runs[i] = 0;

    resetn = 1'b0; en = 1'b1; swap_req = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(actual()), 32'h0000001);
    resetn = 1'b1;
    cyc = 0;

    first_clk = -1; clk_before_stb = 0; stb_n = 0; stb1 = 0; stb129 = 0;
    row0_stb = 0; oe_run = 0; run_n = 0; cnt_r0 = 0; cnt_b1 = 0; cnt_other = 0;
    while (stb_n < 129 && cyc < 26000) begin
      tick();
      if (pclk && first_clk < 0) first_clk = cyc;
      if (pclk && stb_n == 0) clk_before_stb++;
      if (stb_n < 128) begin
        cnt_r0 += int'(r0);
        cnt_b1 += int'(b1);
        cnt_other += int'(g0) + int'(b0) + int'(r1) + int'(g1);
      end
      if (!poe) oe_run++;
      else if (oe_run > 0) begin
        if (run_n < 8) runs[run_n] = oe_run;
        run_n++;
        oe_run = 0;
      end
      if (pstb) begin
        stb_n++;
        if (stb_n == 1) begin
          stb1 = cyc;
          check("first_stb_row", 32'({pd, pc, pb, pa}), 0);
          check("clk_pulses_plane0", clk_before_stb, 32);
        end
        if (stb_n <= 128 && {pd, pc, pb, pa} == 4'd0) row0_stb++;
        if (stb_n == 129) stb129 = cyc;
      end
    end
    check("frame1_timeout", stb_n, 129);
    check("first_clk_cycle", first_clk, 5);
    check("first_stb_cycle", stb1, 130);
    for (int p = 0; p < 8; p++) check("oe_low_plane", runs[p], 2 << p);
    check("stb_per_row", row0_stb, 8);
    check("frame_len", stb129 - stb1, 24800);
    check("r0_lit_cycles", cnt_r0, 4);
    check("b1_lit_cycles", cnt_b1, 4);
    check("other_lit_cycles", cnt_other, 0);

    repeat ($urandom_range(1000, 15000)) tick();
    swap_req = 1'b1;
    n = 0;
    while (!swap_ack && n < 30000) begin tick(); n++; end
    check("swap_ack_cycle", cyc, 49601);
    check("swap_first_read", 32'({mem_rd, mem_addr}), 32'({1'b1, 11'h400}));
    tick();
    check("swap_ack_width", 32'(swap_ack), 0);

    n = 0;
    while (!(m.run && m.plane == 3) && n < 2000) begin tick(); n++; end
    check("reach_plane3", m.plane, 3);
    en = 1'b0;
    n = 0;
    while (poe && n < 300) begin tick(); n++; end
    low = 0;
    while (!poe && low < 300) begin tick(); low++; end
    check("plane3_on_time", low, 16);
    repeat ($urandom_range(3, 30)) tick();
    check("idle_blank", 32'({poe, pclk, pstb, mem_rd}), 32'b1000);
    en = 1'b1;
    n = 0;
    while (!pstb && n < 300) begin tick(); n++; end
    check("resume_row", 32'({pd, pc, pb, pa}), 0);
    n = 0;
    while (poe && n < 300) begin tick(); n++; end
    low = 0;
    while (!poe && low < 300) begin tick(); low++; end
    check("resume_plane4_on_time", low, 32);

    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(50, 2000)) tick();
      en = 1'b0;
      repeat ($urandom_range(1, 300)) tick();
      en = 1'b1;
    end

    seen15 = 0;
    n = 0;
    while (n < 40000) begin
      tick();
      n++;
      if (pstb && {pd, pc, pb, pa} == 4'd15) seen15 = 1;
      if (pstb && {pd, pc, pb, pa} == 4'd0 && seen15) break;
    end
    check("frame3_end_reached", 32'(seen15), 1);
    check("held_req_no_second_ack", ack_total, 1);
    swap_req = 1'b0;

    n = 0;
    while (poe && n < 2000) begin tick(); n++; end
    tick();
    check("pre_reset_front", 32'(front_buf), 1);
    check("pre_reset_display", 32'(poe), 0);
    #2 resetn = 1'b0;
    #1;
    check("async_reset_blank", 32'({poe, pstb, pclk, front_buf, swap_ack}), 32'b10000);
    en = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    repeat (20) tick();
    check("no_ack_after_reset", ack_total, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
